// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// Converts a simple request/grant handshake into APB3 transfers
// (IDLE -> SETUP -> ACCESS). Each accepted request produces exactly one
// rvalid_o pulse, which carries either the slave response or a timeout abort.
//
// Parameters
//   ADDR_WIDTH     : width of addr_i and PADDR
//   TIMEOUT_CYCLES : ACCESS-phase cycles allowed before abort (0 = no timeout)
//
// Ports
//   PCLK, PRESETn            : clock, asynchronous active-low reset
//   req_i, we_i, addr_i,     : requester side; fields sampled on the grant edge
//   wdata_i, gnt_o           : gnt_o is combinational (IDLE && req_i)
//   rvalid_o, rdata_o, err_o : one-cycle response; data/err are 0 otherwise
//   PADDR, PSEL, PENABLE,    : APB master outputs, all registered
//   PWRITE, PWDATA
//   PRDATA, PREADY           : APB slave response
// -----------------------------------------------------------------------------
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY
);

  // A zero timeout still needs a legal (1-bit) counter vector.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_INT);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  wait_cnt_r, wait_cnt_s;
  logic              gnt_s;
  logic              done_s;
  logic              abort_s;
  logic              timeout_hit_s;

  logic              psel_r, penable_r, pwrite_r;
  logic [ADDR_WIDTH-1:0] paddr_r;
  logic [31:0]       pwdata_r;
  logic              rvalid_r, err_r;
  logic [31:0]       rdata_r;

  // Last permitted wait cycle: PREADY still low here means abort.
  assign timeout_hit_s = TO_EN && (wait_cnt_r == TO_LAST);

  // Next-state, grant and completion decode.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    gnt_s      = 1'b0;
    done_s     = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Gated with reset so a held request is never granted during reset.
        if (req_i && PRESETn) begin
          gnt_s   = 1'b1;
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        wait_cnt_s = {CNT_W{1'b0}};
        state_s    = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else if (timeout_hit_s) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          wait_cnt_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          state_s    = ST_ACCESS;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        wait_cnt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  // APB outputs: strobes follow the next state, fields load only on grant.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= {ADDR_WIDTH{1'b0}};
      pwdata_r  <= 32'h0000_0000;
    end else begin
      psel_r    <= (state_s != ST_IDLE);
      penable_r <= (state_s == ST_ACCESS);
      if (gnt_s) begin
        pwrite_r <= we_i;
        paddr_r  <= addr_i;
        pwdata_r <= wdata_i;
      end else begin
        pwrite_r <= pwrite_r;
        paddr_r  <= paddr_r;
        pwdata_r <= pwdata_r;
      end
    end
  end

  // Response pulse: data only for completed reads, err only for aborts.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 32'h0000_0000;
    end else begin
      rvalid_r <= done_s | abort_s;
      err_r    <= abort_s;
      rdata_r  <= (done_s && !pwrite_r) ? PRDATA : 32'h0000_0000;
    end
  end

  assign gnt_o    = gnt_s;
  assign rvalid_o = rvalid_r;
  assign err_o    = err_r;
  assign rdata_o  = rdata_r;
  assign PSEL     = psel_r;
  assign PENABLE  = penable_r;
  assign PWRITE   = pwrite_r;
  assign PADDR    = paddr_r;
  assign PWDATA   = pwdata_r;

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Directed and randomized transfers against apb_master (TIMEOUT_CYCLES = 4).
// The bench plays both requester and APB slave. For each transfer it derives
// the expected timeline from the transfer's wait-state count alone: completion
// after 3+waits cycles, or a timeout after 2+TIMEOUT cycles when waits >= 4.
// -----------------------------------------------------------------------------
module tb_apb_master;

  localparam int TO = 4;

  logic        PCLK    = 1'b0;
  logic        PRESETn = 1'b0;
  logic        req_i   = 1'b0;
  logic        we_i    = 1'b0;
  logic [31:0] addr_i  = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] PRDATA  = 32'h0;
  logic        PREADY  = 1'b0;
  logic        gnt_o, rvalid_o, err_o, PSEL, PENABLE, PWRITE;
  logic [31:0] rdata_o, PADDR, PWDATA;

  int n_vec  = 0;
  int n_err  = 0;
  int n_rv   = 0;
  int exp_rv = 0;

  apb_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Count response pulses actually seen.
  always @(negedge PCLK) begin
    if (rvalid_o === 1'b1) n_rv = n_rv + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer starting in IDLE. If chain is set, req_i stays high and the
  // next transfer's fields are presented right after this grant.
  task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int waits, input bit chain,
                     input bit nwe, input logic [31:0] na, input logic [31:0] nwd);
    bit ex_err;
    int lat;
    we_i = we; addr_i = a; wdata_i = wd; req_i = 1'b1;
    #1;
    chk("gnt", gnt_o, 1);
    ex_err = (waits >= TO);
    lat    = ex_err ? (2 + TO) : (3 + waits);
    exp_rv++;
    for (int c = 1; c <= lat; c++) begin
      @(negedge PCLK);
      if (c == 1) begin
        if (chain) begin
          we_i = nwe; addr_i = na; wdata_i = nwd;
        end else begin
          req_i = 1'b0;
        end
      end
      #1;
      chk("psel",    PSEL,    c < lat);
      chk("penable", PENABLE, (c >= 2) && (c < lat));
      chk("paddr",   PADDR,   a);
      chk("pwrite",  PWRITE,  we);
      chk("pwdata",  PWDATA,  wd);
      chk("rvalid",  rvalid_o, c == lat);
      chk("err",     err_o,   (c == lat) && ex_err);
      chk("rdata",   rdata_o, ((c == lat) && !we && !ex_err) ? rd : 32'h0);
      if (c < lat) chk("gnt_busy", gnt_o, 0);
      else if (chain) chk("gnt_b2b", gnt_o, 1);
      // Slave: answer after 'waits' wait states, junk data otherwise.
      if ((c >= 2) && (c < lat)) begin
        PREADY = ((c - 2) == waits);
        PRDATA = PREADY ? rd : $urandom;
      end else begin
        PREADY = 1'b0;
        PRDATA = $urandom;
      end
    end
  endtask

  // Reset asserted mid-ACCESS: transfer must vanish without a response.
  task automatic txn_reset(input logic [31:0] a, input logic [31:0] wd);
    we_i = 1'b1; addr_i = a; wdata_i = wd; req_i = 1'b1;
    #1;
    chk("rst_gnt", gnt_o, 1);
    @(negedge PCLK); req_i = 1'b0; #1;
    chk("rst_setup_psel", PSEL, 1);
    @(negedge PCLK); #1;
    chk("rst_access_pen", PENABLE, 1);
    PREADY = 1'b0;
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_psel",    PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr",   PADDR, 0);
    chk("rst_pwdata",  PWDATA, 0);
    chk("rst_pwrite",  PWRITE, 0);
    chk("rst_rvalid",  rvalid_o, 0);
    @(negedge PCLK); PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK); #1;
      chk("post_rst_rvalid", rvalid_o, 0);
      chk("post_rst_psel",   PSEL, 0);
    end
  endtask

  initial begin
    // Reset state, with a request already held high.
    req_i = 1'b1;
    repeat (2) @(negedge PCLK);
    #1;
    chk("reset_gnt",     gnt_o, 0);
    chk("reset_psel",    PSEL, 0);
    chk("reset_penable", PENABLE, 0);
    chk("reset_pwrite",  PWRITE, 0);
    chk("reset_paddr",   PADDR, 0);
    chk("reset_pwdata",  PWDATA, 0);
    chk("reset_rvalid",  rvalid_o, 0);
    chk("reset_rdata",   rdata_o, 0);
    chk("reset_err",     err_o, 0);
    req_i = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    @(negedge PCLK);

    // Zero-wait write, then read with 3 waits.
    txn(1'b1, 32'h4, 32'hA5, 32'h0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    txn(1'b0, 32'h8, 32'hDEAD_0000, 32'h1234_5678, 3, 1'b0, 1'b0, 32'h0, 32'h0);
    // Timeout, then ready in the final allowed cycle.
    txn(1'b0, 32'hC, 32'h0, 32'hCAFE_F00D, 4, 1'b0, 1'b0, 32'h0, 32'h0);
    txn(1'b0, 32'h10, 32'h0, 32'h0BAD_BEEF, 3, 1'b0, 1'b0, 32'h0, 32'h0);
    txn(1'b1, 32'h14, 32'h55, 32'h0, 3, 1'b0, 1'b0, 32'h0, 32'h0);
    // Back-to-back writes with req_i held.
    txn(1'b1, 32'h20, 32'h11, 32'h0, 0, 1'b1, 1'b1, 32'h24, 32'h22);
    txn(1'b1, 32'h24, 32'h22, 32'h0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge PCLK); #1;
    chk("b2b_after_rvalid", rvalid_o, 0);

    // Reset during ACCESS, then a normal read.
    @(negedge PCLK);
    txn_reset(32'h30, 32'h77);
    txn(1'b0, 32'h34, 32'h0, 32'h600D_0001, 1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Randomized transfers, waits spanning both completion and timeout.
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge PCLK);
      txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
          int'($urandom_range(0, 6)), 1'b0, 1'b0, 32'h0, 32'h0);
    end

    repeat (2) @(negedge PCLK);
    #1;
    chk("rvalid_count", n_rv, exp_rv);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
